// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_shift parallel-in/serial-out block.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int PISO_DEF_WIDTH = 4;

    // Bit-counter width for a word of the given length; never below one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit counter for piso_shift: counts serialized bits of the current word and
// flags the terminal count (count == WIDTH-1). Clear has priority over enable.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] count;

    // Count enabled bits; cleared on every word boundary so it stays <= WIDTH-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift.sv
// Parallel-in, serial-out shift register with valid/ready word load.
// Build option: define PISO_MSB_FIRST_EN to emit MSB first (default LSB first).
//
//   state | meaning
//   IDLE  | no word held; ready for a load, dout forced low
//   SHIFT | word in flight; dout_valid high, one bit per enabled cycle
module piso_shift
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             last
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic             out_bit;
    logic             tc;
    logic             shift_go;
    logic             word_done;
    logic             load_fire;

`ifdef PISO_MSB_FIRST_EN
    assign shift_nxt = {shift_q[WIDTH-2:0], 1'b0};
    assign out_bit   = shift_q[WIDTH-1];
`else
    assign shift_nxt = {1'b0, shift_q[WIDTH-1:1]};
    assign out_bit   = shift_q[0];
`endif

    assign shift_go  = (state_q == SHIFT) && shift_en;
    assign word_done = shift_go && tc;
    assign load_fire = load_valid && load_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE on a load; return only when a word ends with no follow-on.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_valid) state_d = SHIFT;
            SHIFT:   if (word_done && !load_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready in IDLE and on the completion cycle so words can run gapless.
    always_comb begin
        load_ready = 1'b0;
        dout_valid = 1'b0;
        dout       = 1'b0;
        last       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                load_ready = word_done;
                dout_valid = 1'b1;
                dout       = out_bit;
                last       = tc;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

    // Shift register: capture on handshake, otherwise shift on enabled SHIFT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (load_fire) begin
            shift_q <= din;
        end else if (shift_go) begin
            shift_q <= shift_nxt;
        end
    end

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .en  (shift_go),
        .clr (load_fire || word_done),
        .tc  (tc)
    );

endmodule

// File: tb/tb_piso_shift.sv
// Directed bench for piso_shift with a bit-level scoreboard and a 4-bit SIPO loopback.
module tb_piso_shift;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] din = '0;
    logic         shift_en = 1'b0;
    logic         dout;
    logic         dout_valid;
    logic         last;

    typedef struct {
        logic         d;
        logic         l;
        logic [W-1:0] word;
    } bit_t;

    bit_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] sipo_q;
    logic         sipo_pend = 1'b0;
    logic [W-1:0] sipo_exp = '0;
    logic         accepted = 1'b0;

    piso_shift #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .din        (din),
        .shift_en   (shift_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .last       (last)
    );

    always #5 clk = ~clk;

    // Receiving 4-bit SIPO: shifts the serial bit into its MSB.
    always @(posedge clk or negedge rst) begin
        if (!rst) sipo_q <= '0;
        else if (dout_valid && shift_en) sipo_q <= {dout, sipo_q[W-1:1]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sipo_word(input logic [W-1:0] w);
        logic [W-1:0] r;
`ifdef PISO_MSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        bit_t e;
        for (int i = 0; i < W; i++) begin
`ifdef PISO_MSB_FIRST_EN
            e.d = w[W-1-i];
`else
            e.d = w[i];
`endif
            e.l    = (i == W - 1);
            e.word = w;
            sb.push_back(e);
        end
    endtask

    // One clock cycle: inputs already driven; check outputs, update model, advance.
    task automatic cycle();
        logic exp_v;
        logic exp_r;
        bit_t e;
        #1;
        if (sipo_pend) begin
            chk("sipo_q", sipo_q, sipo_exp);
            sipo_pend = 1'b0;
        end
        exp_v = (sb.size() != 0);
        exp_r = (sb.size() == 0) || (sb.size() == 1 && shift_en);
        chk("dout_valid", dout_valid, exp_v);
        chk("load_ready", load_ready, exp_r);
        if (exp_v) begin
            e = sb[0];
            chk("dout", dout, e.d);
            chk("last", last, e.l);
            if (shift_en) begin
                void'(sb.pop_front());
                if (e.l) begin
                    sipo_pend = 1'b1;
                    sipo_exp  = sipo_word(e.word);
                end
            end
        end else begin
            chk("dout_idle", dout, 0);
            chk("last_idle", last, 0);
        end
        accepted = load_valid && exp_r;
        if (accepted) push_word(din);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic lv, input logic [W-1:0] d, input logic se);
        load_valid = lv;
        din        = lv ? d : W'($urandom);
        shift_en   = se;
        cycle();
    endtask

    task automatic idle_n(input int n, input logic se);
        for (int i = 0; i < n; i++) drive(1'b0, '0, se);
    endtask

    // Hold the word on din until the model accepts it, bounded.
    task automatic send_word(input logic [W-1:0] w);
        int n = 0;
        do begin
            drive(1'b1, w, 1'b1);
            n++;
        end while (!accepted && n < 40);
        chk("send_accept", accepted, 1);
    endtask

    task automatic reset_mid();
        load_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_last", last, 0);
        chk("rst_load_ready", load_ready, 1);
        sb.delete();
        sipo_pend = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_last", last, 0);
        chk("reset_load_ready", load_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // Single word 1011 with continuous enable.
        drive(1'b1, 4'b1011, 1'b1);
        idle_n(6, 1'b1);

        // Back-to-back A then 5, second word held until accepted.
        drive(1'b1, 4'hA, 1'b1);
        send_word(4'h5);
        idle_n(5, 1'b1);

        // Stall: load 0110 with enable low (ignored in IDLE), stall after two bits.
        drive(1'b1, 4'b0110, 1'b0);
        idle_n(2, 1'b1);
        idle_n(3, 1'b0);
        idle_n(4, 1'b1);

        // Busy load of F during word 3 must be ignored.
        drive(1'b1, 4'h3, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, 4'hF, 1'b1);
        idle_n(5, 1'b1);

        // Reset after two bits of 9, then send 6.
        drive(1'b1, 4'h9, 1'b1);
        idle_n(2, 1'b1);
        reset_mid();
        idle_n(1, 1'b1);
        drive(1'b1, 4'h6, 1'b1);
        idle_n(5, 1'b1);

        // Loopback with random back-to-back words.
        for (int k = 0; k < 8; k++) send_word(W'($urandom_range(0, 15)));
        idle_n(6, 1'b1);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
